interleaver_bit_packer: RTL and testbench
=========================================

// Module: interleaver_bit_packer
// PURPOSE
//  Downstream stage of the row-in/column-out block interleaver. Consumes the interleaver's
//  1-bit AXI-Stream output and packs it serially into WIDTH-bit words for byte-wide logic
//  (FIFO/DMA/mapper). Tracks interleaver block boundaries via s_axis_tlast: a partial final
//  word is zero-padded and flagged. Full throughput: one bit per clock.
// PARAMETERS
//  WIDTH      8  output word width in bits; legal range 2..32
//  MSB_FIRST  1  1: first received bit -> m_axis_tdata[WIDTH-1]; 0: first bit -> m_axis_tdata[0]
// PORTS
//  clk            in   1                    system clock, rising edge
//  rst_n          in   1                    asynchronous active-low reset
//  s_axis_tdata   in   1                    interleaved bit
//  s_axis_tvalid  in   1                    input bit valid
//  s_axis_tlast   in   1                    last bit of interleaver block
//  s_axis_tready  out  1                    packer can accept a bit
//  m_axis_tdata   out  WIDTH                packed word
//  m_axis_tvalid  out  1                    word valid
//  m_axis_tlast   out  1                    word holds the block's last bit
//  m_axis_tbits   out  $clog2(WIDTH)+1      count of valid bits in word (1..WIDTH)
// BEHAVIOUR
//  - Reset (async assert, sync release): m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0,
//    m_axis_tbits=0, bit counter=0, accumulator=0, en_q=0. s_axis_tready=0 during reset.
//  - en_q flop goes 1 on first clk edge after release.
//    s_axis_tready = en_q & (~m_axis_tvalid | m_axis_tready), combinational.
//    No path from s_axis_tvalid to s_axis_tready.
//  - Transfer = tvalid & tready on the respective side; no other event changes state.
//  - Accumulate: bit k (k=0..WIDTH-1, counter value) is placed at index WIDTH-1-k (MSB_FIRST=1)
//    or at index k (MSB_FIRST=0).
//  - Flush condition: accepted bit with counter==WIDTH-1, or accepted bit with s_axis_tlast=1.
//    On flush:
//    - Next edge loads the output register: tdata = accumulator incl. this bit, unfilled
//      positions 0; tbits = counter+1; tlast = s_axis_tlast; tvalid = 1.
//    - Counter and accumulator clear to 0.
//    - Latency: completing bit accepted in cycle N -> word valid in cycle N+1.
//  - Output register holds tdata/tbits/tlast stable while tvalid & ~tready (AXIS rule).
//    - tvalid clears on an accepted word unless a new flush happens in the same cycle; in that
//      case the new word is loaded back-to-back with no bubble.
//  - Boundaries:
//    - tlast on a bit completing a full word -> tbits=WIDTH, tlast=1. No extra empty word.
//    - tlast on counter=0 -> 1-bit word, tbits=1.
//    - Stall while m_axis_tvalid & ~m_axis_tready blocks all input, even mid-word.
//    - Counter wraps only via flush; never exceeds WIDTH-1.
//    - Reset mid-word or mid-output discards the partial word and any pending word.
//  - States (implicit): IDLE(en_q=0) -> COLLECT(tvalid=0) <-> HOLD(tvalid=1); COLLECT->HOLD on
//    flush; HOLD->COLLECT on accept without flush; HOLD->HOLD on accept+flush or stall.
// CONFIGURATION
//  - `define PACKER_PARITY_EN: adds output port m_axis_tparity (1 bit). It is the even parity
//    (XOR) of the m_axis_tdata bits, registered with the word. It follows the same
//    reset (0) and hold rules as tdata.
//  - Without the macro the port does not exist and no parity logic is built.
// TESTING
//  1. WIDTH=8, MSB_FIRST=1, m_tready=1, bits 1,0,1,1,0,0,1,0 back-to-back -> one word 8'hB2,
//     tbits=8, tlast=0; tvalid exactly one cycle after 8th bit accepted.
//  2. Same bits, MSB_FIRST=0 -> 8'h4D, tbits=8.
//  3. 11 ones, tlast on 11th -> word 8'hFF tbits=8 tlast=0, then 8'hE0 tbits=3 tlast=1
//     (MSB_FIRST=1); PARITY_EN: parity 0 then 1.
//  4. Full 512x32 block (16384 bits, tlast on last) at 1 bit/clk, random data -> 2048 words
//     matching reference model; tlast only on word 2048; no bubbles.
//  5. Backpressure: drop m_tready for 20 cycles after a word goes valid -> s_tready=0
//     same cycle; tdata/tbits/tlast stable; no bit lost or duplicated after release.
//  6. Assert rst_n after 5 bits of a word -> all outputs 0 asynchronously; s_tready=0 until
//     1 cycle after release; next 8 bits form a clean fresh word.

Source files
------------

// File: rtl/interleaver_bit_packer.sv
// Serial-to-parallel packer behind the block interleaver: collects one bit per clock into
// WIDTH-bit words, flushing early (zero-padded) on s_axis_tlast.
// Optional build macro PACKER_PARITY_EN adds m_axis_tparity, the XOR of the registered word.
// Implicit states: idle (en_q=0), collect (m_axis_tvalid=0), hold (m_axis_tvalid=1).
module interleaver_bit_packer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [WIDTH-1:0]         m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic [$clog2(WIDTH):0]   m_axis_tbits,
  input  logic                     m_axis_tready
`ifdef PACKER_PARITY_EN
  ,
  output logic                     m_axis_tparity
`endif
);

  localparam int CW  = $clog2(WIDTH);
  localparam int TBW = CW + 1;

  logic             en_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [TBW-1:0]   bits_q, bits_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             parity_q, parity_d;

  logic             in_xfer;
  logic             out_xfer;
  logic             flush;
  logic [WIDTH-1:0] acc_bit;
  int               pos;

  // Input may only advance when the output slot is free or being drained this cycle.
  assign s_axis_tready = en_q & (~valid_q | m_axis_tready);
  assign in_xfer       = s_axis_tvalid & s_axis_tready;
  assign out_xfer      = valid_q & m_axis_tready;
  assign flush         = in_xfer & ((cnt_q == CW'(WIDTH - 1)) | s_axis_tlast);

  // Accumulator image including the bit currently offered.
  always_comb begin
    pos     = MSB_FIRST ? (WIDTH - 1 - int'(cnt_q)) : int'(cnt_q);
    acc_bit = acc_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == pos) acc_bit[i] = s_axis_tdata;
    end
  end

  // Next-state for bit collection and the output word register.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_d   = data_q;
    bits_d   = bits_q;
    last_d   = last_q;
    valid_d  = valid_q;
    parity_d = parity_q;
    if (in_xfer) begin
      if (flush) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        acc_d = acc_bit;
      end
    end
    // A flush while a word is pending implies that word is being accepted now.
    if (flush) begin
      data_d   = acc_bit;
      bits_d   = TBW'(cnt_q) + TBW'(1);
      last_d   = s_axis_tlast;
      valid_d  = 1'b1;
      parity_d = ^acc_bit;
    end else if (out_xfer) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset discards any partial or pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      bits_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      en_q     <= 1'b1;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      bits_q   <= bits_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      parity_q <= parity_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tbits  = bits_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tvalid = valid_q;

`ifdef PACKER_PARITY_EN
  assign m_axis_tparity = parity_q;
`else
  logic unused_parity;
  assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_interleaver_bit_packer.sv
// Bench for interleaver_bit_packer: MSB-first and LSB-first instances share one input stream
// and are checked against a queue-based word model, a vector table and directed sequences.
module tb_interleaver_bit_packer;

  localparam int WIDTH = 8;
  localparam int TBW   = $clog2(WIDTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_tdata = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;

  logic             rdy_m, rdy_l;
  logic [WIDTH-1:0] dat_m, dat_l;
  logic             val_m, val_l, lst_m, lst_l;
  logic [TBW-1:0]   bit_m, bit_l;
`ifdef PACKER_PARITY_EN
  logic             par_m, par_l;
`endif

  always #5 clk = ~clk;

  interleaver_bit_packer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(rdy_m), .m_axis_tdata(dat_m),
    .m_axis_tvalid(val_m), .m_axis_tlast(lst_m), .m_axis_tbits(bit_m),
    .m_axis_tready(m_tready)
`ifdef PACKER_PARITY_EN
    , .m_axis_tparity(par_m)
`endif
  );

  interleaver_bit_packer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(rdy_l), .m_axis_tdata(dat_l),
    .m_axis_tvalid(val_l), .m_axis_tlast(lst_l), .m_axis_tbits(bit_l),
    .m_axis_tready(m_tready)
`ifdef PACKER_PARITY_EN
    , .m_axis_tparity(par_l)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int words    = 0;
  int lasts    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    logic [WIDTH-1:0] dm;
    logic [WIDTH-1:0] dl;
    int               bits;
    logic             last;
  } word_t;

  logic  bit_q[$];
  word_t exp_q[$];
  logic  en_m;
  logic  hold_p;
  logic [63:0] snap_m, snap_l;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_m <= 1'b0;
    else        en_m <= 1'b1;
  end

  always @(negedge rst_n) begin
    bit_q.delete();
    exp_q.delete();
    hold_p = 1'b0;
  end

  function automatic word_t build_word(input logic last);
    word_t w;
    w.dm   = '0;
    w.dl   = '0;
    w.bits = bit_q.size();
    w.last = last;
    for (int k = 0; k < w.bits; k++) begin
      w.dm[WIDTH-1-k] = bit_q[k];
      w.dl[k]         = bit_q[k];
    end
    return w;
  endfunction

  // Scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      word_t e;
      chk("s_tready_msb", rdy_m, en_m & (~(exp_q.size() != 0) | m_tready));
      chk("s_tready_lsb", rdy_l, en_m & (~(exp_q.size() != 0) | m_tready));
      chk("tvalid_msb", val_m, exp_q.size() != 0);
      chk("tvalid_lsb", val_l, exp_q.size() != 0);
      if (hold_p && val_m) begin
        chk("hold_msb", {dat_m, bit_m, lst_m}, snap_m);
        chk("hold_lsb", {dat_l, bit_l, lst_l}, snap_l);
      end
      if (val_m && m_tready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        words++;
        if (e.last) lasts++;
        chk("word_msb", {dat_m, bit_m, lst_m}, {e.dm, TBW'(e.bits), e.last});
        chk("word_lsb", {dat_l, bit_l, lst_l}, {e.dl, TBW'(e.bits), e.last});
`ifdef PACKER_PARITY_EN
        chk("parity_msb", par_m, ^e.dm);
        chk("parity_lsb", par_l, ^e.dl);
`endif
      end
      hold_p = val_m && !m_tready;
      snap_m = {dat_m, bit_m, lst_m};
      snap_l = {dat_l, bit_l, lst_l};
      if (s_tvalid && rdy_m) begin
        bit_q.push_back(s_tdata);
        if (bit_q.size() == WIDTH || s_tlast) begin
          exp_q.push_back(build_word(s_tlast));
          bit_q.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the edge that accepted the bit.
  task automatic send_bit(input logic b, input logic l);
    logic acc;
    s_tdata  = b;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = s_tvalid && rdy_m;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_msb"}, {rdy_m, dat_m, val_m, lst_m, bit_m}, '0);
    chk({nm, "_lsb"}, {rdy_l, dat_l, val_l, lst_l, bit_l}, '0);
`ifdef PACKER_PARITY_EN
    chk({nm, "_par"}, {par_m, par_l}, 2'b00);
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] pat;    // pat[k] is the k-th bit sent
    int          n;
    logic        last;
    logic [7:0]  em;
    logic [7:0]  el;
    int          eb;
    logic        elast;
  } vec_t;

  vec_t vt[5];

  initial begin
    int wd0, ls0, c0;
    logic [31:0] p;
    vt[0] = '{pat: 32'h4D, n: 8, last: 1'b0, em: 8'hB2, el: 8'h4D, eb: 8, elast: 1'b0};
    vt[1] = '{pat: 32'h01, n: 1, last: 1'b1, em: 8'h80, el: 8'h01, eb: 1, elast: 1'b1};
    vt[2] = '{pat: 32'h07, n: 3, last: 1'b1, em: 8'hE0, el: 8'h07, eb: 3, elast: 1'b1};
    vt[3] = '{pat: 32'hFF, n: 8, last: 1'b1, em: 8'hFF, el: 8'hFF, eb: 8, elast: 1'b1};
    vt[4] = '{pat: 32'h11, n: 5, last: 1'b1, em: 8'h88, el: 8'h11, eb: 5, elast: 1'b1};

    // Reset state
    #12;
    chk_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("tready_before_en", rdy_m, 1'b0);
    @(posedge clk); #1;
    chk("tready_after_en", rdy_m, 1'b1);

    // Table: each record yields one word, valid right after its final bit is accepted
    for (int v = 0; v < 5; v++) begin
      p = vt[v].pat;
      for (int k = 0; k < vt[v].n; k++) send_bit(p[k], vt[v].last && (k == vt[v].n - 1));
      s_tvalid = 1'b0;
      chk($sformatf("vec%0d_msb", v), {val_m, dat_m, bit_m, lst_m},
          {1'b1, vt[v].em, TBW'(vt[v].eb), vt[v].elast});
      chk($sformatf("vec%0d_lsb", v), {val_l, dat_l, bit_l, lst_l},
          {1'b1, vt[v].el, TBW'(vt[v].eb), vt[v].elast});
      idle(2);
    end

    // Eleven ones with tlast on the eleventh: full word then a 3-bit padded word
    for (int k = 0; k < 8; k++) send_bit(1'b1, 1'b0);
    chk("ones_w0", {val_m, dat_m, bit_m, lst_m}, {1'b1, 8'hFF, TBW'(8), 1'b0});
    for (int k = 0; k < 3; k++) send_bit(1'b1, k == 2);
    s_tvalid = 1'b0;
    chk("ones_w1", {val_m, dat_m, bit_m, lst_m}, {1'b1, 8'hE0, TBW'(3), 1'b1});
    idle(2);

    // Full 512x32 block at one bit per clock
    wd0 = words;
    ls0 = lasts;
    c0  = cyc;
    for (int k = 0; k < 16384; k++) send_bit(1'($urandom), k == 16383);
    chk("block_no_bubble", cyc - c0, 16384);
    idle(3);
    chk("block_words", words - wd0, 2048);
    chk("block_lasts", lasts - ls0, 1);

    // Backpressure: 20-cycle stall as soon as a word is valid
    wd0 = words;
    fork
      begin
        for (int k = 0; k < 40; k++) send_bit(1'($urandom), k == 39);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
      begin
        for (int t = 0; t < 50; t++) begin
          @(posedge clk); #1;
          if (val_m) break;
        end
        m_tready = 1'b0;
        #1;
        chk("bp_tready_drop", rdy_m, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    idle(3);
    chk("bp_words", words - wd0, 5);
    chk("bp_drained", exp_q.size() + bit_q.size(), 0);

    // Reset mid-word, then a fresh word
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_midword");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_tready_release", rdy_m, 1'b0);
    @(posedge clk); #1;
    chk("rst_tready_en", rdy_m, 1'b1);
    p = vt[0].pat;
    for (int k = 0; k < 8; k++) send_bit(p[k], 1'b0);
    s_tvalid = 1'b0;
    chk("rst_fresh_word", {val_m, dat_m, bit_m, lst_m}, {1'b1, 8'hB2, TBW'(8), 1'b0});
    idle(2);

    // Reset with a word pending under backpressure
    m_tready = 1'b0;
    for (int k = 0; k < 8; k++) send_bit(1'b1, 1'b0);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_pending");
    m_tready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
